rou_buf_allocator: RTL and testbench

//   Registered free-buffer manager for the roubus buffer pool. Tracks occupancy of BUFS buffers,

---
 rtl/rou_pkg.sv | 25 ++
 rtl/rou_find_free.sv | 35 +++
 rtl/rou_buf_allocator.sv | 175 +++++++++++++++++
 tb/tb_rou_buf_allocator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rou_pkg.sv
// ---------------------------------------------------------------------------
// rou_pkg
//   Shared defaults and helpers for the roubus buffer-pool allocator.
//   ROU_BUFS / ROU_WBUFS / ROU_NALLOC : default pool size, index width and
//                                       grants per cycle.
//   popcount(v)                       : number of set bits in a 64-bit vector.
// ---------------------------------------------------------------------------
package rou_pkg;

    localparam int ROU_BUFS   = 32;
    localparam int ROU_WBUFS  = 5;
    localparam int ROU_NALLOC = 3;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                cnt = cnt + 7'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rou_find_free.sv
// ---------------------------------------------------------------------------
// rou_find_free
//   One trailing-one search stage. Finds the lowest set bit of vec_in and
//   passes the vector on with that bit cleared so stages can be chained.
//   Ports:
//     vec_in  [W-1:0]    candidate vector (1 = free)
//     index   [WIDX-1:0] position of the lowest set bit (0 when none)
//     found              vec_in has at least one set bit
//     vec_out [W-1:0]    vec_in with its lowest set bit cleared
// ---------------------------------------------------------------------------
module rou_find_free #(
    parameter int W    = 32,
    parameter int WIDX = 5
) (
    input  logic [W-1:0]    vec_in,
    output logic [WIDX-1:0] index,
    output logic            found,
    output logic [W-1:0]    vec_out
);

    // Scan downward so the last hit written is the lowest set bit.
    always_comb begin
        index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_in[i]) begin
                index = WIDX'(i);
            end
        end
    end

    assign found   = |vec_in;
    // x & (x-1) clears exactly the lowest set bit.
    assign vec_out = vec_in & (vec_in - W'(1));

endmodule

// File: rtl/rou_buf_allocator.sv
// ---------------------------------------------------------------------------
// rou_buf_allocator
//   Free-buffer manager for the roubus buffer pool. Grants up to NALLOC of
//   the lowest free buffers per cycle (all-or-nothing) and retires up to NREL
//   buffers per cycle. Keeps a registered free count, a low-watermark flag
//   and a sticky error flag for illegal releases.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     alloc_req       allocation request this cycle
//     alloc_num       buffers requested (1..NALLOC)
//     alloc_ok        request accepted this cycle (combinational)
//     alloc_indx      granted indices, slot k at [k*WBUFS +: WBUFS]
//     rel_vld         per-port release strobe
//     rel_indx        per-port released index, port p at [p*WBUFS +: WBUFS]
//     free_cnt        registered free buffer count
//     low_free        registered, free_cnt <= LOWMARK
//     err             sticky illegal-release flag, cleared by rst only
// ---------------------------------------------------------------------------
module rou_buf_allocator
    import rou_pkg::*;
#(
    parameter int BUFS    = ROU_BUFS,
    parameter int WBUFS   = ROU_WBUFS,
    parameter int NALLOC  = ROU_NALLOC,
    parameter int NREL    = 2,
    parameter int LOWMARK = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_req,
    input  logic [$clog2(NALLOC+1)-1:0] alloc_num,
    output logic                        alloc_ok,
    output logic [NALLOC*WBUFS-1:0]     alloc_indx,
    input  logic [NREL-1:0]             rel_vld,
    input  logic [NREL*WBUFS-1:0]       rel_indx,
    output logic [WBUFS:0]              free_cnt,
    output logic                        low_free,
    output logic                        err
);

    localparam int WNUM = $clog2(NALLOC + 1);
    localparam int WCNT = WBUFS + 1;
    localparam logic [WNUM-1:0] NALLOC_W = WNUM'(NALLOC);
    localparam logic            LOW_RST  = (BUFS <= LOWMARK);

    logic [BUFS-1:0] occupied_q, occupied_d;
    logic [WCNT-1:0] free_cnt_q, free_cnt_d;
    logic            low_free_q, low_free_d;
    logic            err_q, err_d;

    // ------------------------------------------------------------------
    // Allocation: chained trailing-one search over the registered free map.
    // free_vec[k] is the free map with the k lowest free buffers removed.
    // ------------------------------------------------------------------
    logic [BUFS-1:0]  free_vec [NALLOC+1];
    logic [WBUFS-1:0] slot_idx [NALLOC];
    logic [NALLOC-1:0] slot_found;
    logic [BUFS-1:0]  grant_mask;
    logic [WCNT-1:0]  grant_cnt;

    assign free_vec[0] = ~occupied_q;

    generate
        for (genvar gi = 0; gi < NALLOC; gi++) begin : g_stage
            rou_find_free #(
                .W    (BUFS),
                .WIDX (WBUFS)
            ) u_find (
                .vec_in  (free_vec[gi]),
                .index   (slot_idx[gi]),
                .found   (slot_found[gi]),
                .vec_out (free_vec[gi+1])
            );
            // A slot with no free buffer behind it reports index 0.
            assign alloc_indx[gi*WBUFS +: WBUFS] = slot_found[gi] ? slot_idx[gi] : '0;
        end
    endgenerate

    assign alloc_ok = !rst && alloc_req
                      && (alloc_num != '0)
                      && (alloc_num <= NALLOC_W)
                      && (free_cnt_q >= WCNT'(alloc_num));

    // Bits removed between consecutive stages are exactly the granted buffers.
    always_comb begin
        grant_mask = '0;
        for (int k = 0; k < NALLOC; k++) begin
            if (alloc_ok && (WNUM'(k) < alloc_num)) begin
                grant_mask = grant_mask | (free_vec[k] & ~free_vec[k+1]);
            end
        end
    end

    assign grant_cnt = alloc_ok ? WCNT'(alloc_num) : '0;

    // ------------------------------------------------------------------
    // Release decode. A port is legal when its index is in range, the buffer
    // is currently occupied and no lower-numbered port names the same index.
    // Illegal ports are dropped and raise err; the others still act.
    // ------------------------------------------------------------------
    logic [WBUFS-1:0] rel_idx   [NREL];
    logic [BUFS-1:0]  clr_chain [NREL+1];
    logic [NREL-1:0]  rel_legal;
    logic [NREL-1:0]  rel_bad;
    logic [BUFS-1:0]  clr_mask;
    logic [WCNT-1:0]  rel_cnt;

    assign clr_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < NREL; gi++) begin : g_rel
            logic [BUFS-1:0] hit;
            logic            dup;

            assign rel_idx[gi] = rel_indx[gi*WBUFS +: WBUFS];

            // One-hot decode; out-of-range indices decode to all zeros.
            always_comb begin
                hit = '0;
                for (int b = 0; b < BUFS; b++) begin
                    if (int'(rel_idx[gi]) == b) begin
                        hit[b] = 1'b1;
                    end
                end
            end

            always_comb begin
                dup = 1'b0;
                for (int q = 0; q < gi; q++) begin
                    if (rel_vld[q] && (rel_idx[q] == rel_idx[gi])) begin
                        dup = 1'b1;
                    end
                end
            end

            assign rel_legal[gi]     = rel_vld[gi] && (|(hit & occupied_q)) && !dup;
            assign rel_bad[gi]       = rel_vld[gi] && !rel_legal[gi];
            assign clr_chain[gi+1]   = clr_chain[gi] | (rel_legal[gi] ? hit : '0);
        end
    endgenerate

    assign clr_mask = clr_chain[NREL];
    // Legal releases hit distinct occupied bits, so counting mask bits is exact.
    assign rel_cnt  = WCNT'(popcount(64'(clr_mask)));

    // ------------------------------------------------------------------
    // Next state. Granted bits were free and cleared bits were occupied, so
    // the two masks never overlap and the count stays within 0..BUFS.
    // ------------------------------------------------------------------
    always_comb begin
        occupied_d = (occupied_q | grant_mask) & ~clr_mask;
        free_cnt_d = free_cnt_q - grant_cnt + rel_cnt;
        low_free_d = (int'(free_cnt_d) <= LOWMARK);
        err_d      = err_q | (|rel_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupied_q <= '0;
            free_cnt_q <= WCNT'(BUFS);
            low_free_q <= LOW_RST;
            err_q      <= 1'b0;
        end else begin
            occupied_q <= occupied_d;
            free_cnt_q <= free_cnt_d;
            low_free_q <= low_free_d;
            err_q      <= err_d;
        end
    end

    assign free_cnt = free_cnt_q;
    assign low_free = low_free_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rou_buf_allocator.sv
// ---------------------------------------------------------------------------
// tb_rou_buf_allocator
//   Directed bench for rou_buf_allocator with a 32-buffer pool, 3 grants and
//   2 release ports. The index width is 6 bits so that an out-of-range
//   index (40) can be presented on a release port.
// ---------------------------------------------------------------------------
module tb_rou_buf_allocator;

    localparam int BUFS    = 32;
    localparam int WBUFS   = 6;
    localparam int NALLOC  = 3;
    localparam int NREL    = 2;
    localparam int LOWMARK = 4;

    logic                    clk;
    logic                    rst;
    logic                    alloc_req;
    logic [1:0]              alloc_num;
    logic                    alloc_ok;
    logic [NALLOC*WBUFS-1:0] alloc_indx;
    logic [NREL-1:0]         rel_vld;
    logic [NREL*WBUFS-1:0]   rel_indx;
    logic [WBUFS:0]          free_cnt;
    logic                    low_free;
    logic                    err;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    rou_buf_allocator #(
        .BUFS    (BUFS),
        .WBUFS   (WBUFS),
        .NALLOC  (NALLOC),
        .NREL    (NREL),
        .LOWMARK (LOWMARK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_num  (alloc_num),
        .alloc_ok   (alloc_ok),
        .alloc_indx (alloc_indx),
        .rel_vld    (rel_vld),
        .rel_indx   (rel_indx),
        .free_cnt   (free_cnt),
        .low_free   (low_free),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int k);
        return 32'(alloc_indx[k*WBUFS +: WBUFS]);
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0;
        alloc_num = 2'd0;
        rel_vld   = '0;
        rel_indx  = '0;
    endtask

    task automatic drive(input logic req, input logic [1:0] num,
                         input logic v0, input logic [5:0] i0,
                         input logic v1, input logic [5:0] i1);
        alloc_req = req;
        alloc_num = num;
        rel_vld   = {v1, v0};
        rel_indx  = {i1, i0};
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        alloc_req = 1'b1;
        alloc_num = 2'd3;

        // Reset: grants are void while rst is high.
        tick();
        chk("rst_alloc_ok", 32'(alloc_ok), 0);
        tick();
        chk("rst_free_cnt", 32'(free_cnt), 32);
        chk("rst_low_free", 32'(low_free), 0);
        chk("rst_err", 32'(err), 0);

        // First grant of 3 on an empty pool returns 0,1,2.
        rst = 1'b0;
        drive(1, 3, 0, 0, 0, 0);
        chk("g3_ok", 32'(alloc_ok), 1);
        chk("g3_s0", slot(0), 0);
        chk("g3_s1", slot(1), 1);
        chk("g3_s2", slot(2), 2);
        tick();
        idle();
        chk("g3_free", 32'(free_cnt), 29);

        // Release 1; the freed buffer is not visible until the next cycle.
        drive(0, 0, 1, 1, 0, 0);
        chk("rel1_s0_same", slot(0), 3);
        tick();
        idle();
        chk("rel1_free", 32'(free_cnt), 30);
        drive(1, 2, 0, 0, 0, 0);
        chk("g2_ok", 32'(alloc_ok), 1);
        chk("g2_s0", slot(0), 1);
        chk("g2_s1", slot(1), 3);
        tick();
        idle();
        chk("g2_free", 32'(free_cnt), 28);

        // Grant 1 while releasing 2: grant gets 4, not the released 2.
        drive(1, 1, 1, 2, 0, 0);
        chk("gr_ok", 32'(alloc_ok), 1);
        chk("gr_s0", slot(0), 4);
        tick();
        idle();
        chk("gr_free", 32'(free_cnt), 28);
        drive(1, 1, 0, 0, 0, 0);
        chk("g1_s0", slot(0), 2);
        tick();
        idle();
        chk("g1_free", 32'(free_cnt), 27);

        // Drain to 2 free buffers: 8 grants of 3, then one of 1.
        for (int i = 0; i < 8; i++) begin
            drive(1, 3, 0, 0, 0, 0);
            chk("drain_ok", 32'(alloc_ok), 1);
            chk("drain_s0", slot(0), 32'(5 + 3 * i));
            tick();
            idle();
        end
        drive(1, 1, 0, 0, 0, 0);
        chk("drain_last", slot(0), 29);
        tick();
        idle();
        chk("two_free", 32'(free_cnt), 2);
        chk("two_low", 32'(low_free), 1);

        // Asking for 3 with only 2 free is refused outright.
        drive(1, 3, 0, 0, 0, 0);
        chk("short_ok", 32'(alloc_ok), 0);
        chk("short_s0", slot(0), 30);
        chk("short_s2", slot(2), 0);
        tick();
        idle();
        chk("short_free", 32'(free_cnt), 2);

        drive(1, 2, 0, 0, 0, 0);
        chk("last2_ok", 32'(alloc_ok), 1);
        chk("last2_s1", slot(1), 31);
        tick();
        idle();
        chk("full_free", 32'(free_cnt), 0);
        chk("full_low", 32'(low_free), 1);
        drive(1, 1, 0, 0, 0, 0);
        chk("full_ok", 32'(alloc_ok), 0);
        chk("full_indx", 32'(alloc_indx), 0);
        tick();
        idle();

        // Free 10,11, then grant 2 while releasing 5,6 in the same cycle.
        drive(0, 0, 1, 10, 1, 11);
        tick();
        idle();
        chk("r2_free", 32'(free_cnt), 2);
        drive(1, 2, 1, 5, 1, 6);
        chk("mix_ok", 32'(alloc_ok), 1);
        chk("mix_s0", slot(0), 10);
        chk("mix_s1", slot(1), 11);
        tick();
        idle();
        chk("mix_free", 32'(free_cnt), 2);
        drive(1, 2, 0, 0, 0, 0);
        chk("mix_next_s0", slot(0), 5);
        chk("mix_next_s1", slot(1), 6);
        tick();
        idle();
        chk("mix_next_free", 32'(free_cnt), 0);

        // Illegal releases.
        drive(0, 0, 1, 20, 0, 0);
        tick();
        idle();
        chk("e1_free", 32'(free_cnt), 1);
        chk("e1_err", 32'(err), 0);
        drive(0, 0, 1, 20, 1, 21);          // 20 already free
        tick();
        idle();
        chk("e2_free", 32'(free_cnt), 2);
        chk("e2_err", 32'(err), 1);
        tick();
        chk("e2_err_hold", 32'(err), 1);
        drive(0, 0, 1, 22, 1, 40);          // 40 out of range
        tick();
        idle();
        chk("e3_free", 32'(free_cnt), 3);
        drive(0, 0, 1, 23, 1, 23);          // same index on both ports
        tick();
        idle();
        chk("e4_free", 32'(free_cnt), 4);
        chk("e4_low", 32'(low_free), 1);
        chk("e4_err", 32'(err), 1);
        drive(1, 3, 0, 0, 0, 0);
        chk("e_g_s0", slot(0), 20);
        chk("e_g_s1", slot(1), 21);
        chk("e_g_s2", slot(2), 22);
        tick();
        idle();
        chk("e_g_free", 32'(free_cnt), 1);

        // Reset in the middle of traffic.
        rst = 1'b1;
        drive(1, 3, 1, 23, 1, 7);
        chk("mid_rst_ok", 32'(alloc_ok), 0);
        tick();
        rst = 1'b0;
        idle();
        chk("mid_free", 32'(free_cnt), 32);
        chk("mid_err", 32'(err), 0);
        chk("mid_low", 32'(low_free), 0);
        drive(1, 3, 0, 0, 0, 0);
        chk("post_s0", slot(0), 0);
        chk("post_s1", slot(1), 1);
        chk("post_s2", slot(2), 2);
        tick();
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
